// File: rtl/vend_inventory_ctrl.sv
// Per-slot stock counters with code lookup, vend req/ack handshake and saturating restock; LOW_STOCK_ALERT_EN adds low_stock.
// Latency: request sampled at edge N, ack/result/count visible after N+1, next request accepted at N+3.
// Backpressure: busy holds off vend_req for two cycles (dropped, not queued); restock is accepted every cycle.
module vend_inventory_ctrl #(
  parameter int NUM_ITEMS = 4,
  parameter int CNT_W = 3,
  parameter int CODE_W = 8,
  parameter logic [NUM_ITEMS*CODE_W-1:0] ITEM_CODES = {8'hE8, 8'hD5, 8'hB3, 8'hA2},
  parameter logic [NUM_ITEMS*CNT_W-1:0] INIT_COUNTS = {3'd3, 3'd3, 3'd4, 3'd5},
  parameter int LOW_THRESH = 1,
  localparam int SLOT_W = (NUM_ITEMS > 1) ? $clog2(NUM_ITEMS) : 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       vend_req,
  input  logic [CODE_W-1:0]          item_code,
  input  logic                       restock_en,
  input  logic [SLOT_W-1:0]          restock_slot,
  input  logic [CNT_W-1:0]           restock_qty,
  output logic                       busy,
  output logic                       vend_ack,
  output logic                       vend_ok,
  output logic [1:0]                 vend_err,
  output logic [SLOT_W-1:0]          vend_slot,
  output logic [NUM_ITEMS*CNT_W-1:0] counts,
  output logic [NUM_ITEMS-1:0]       sold_out
`ifdef LOW_STOCK_ALERT_EN
  ,
  output logic [NUM_ITEMS-1:0]       low_stock
`endif
);

  localparam logic [CNT_W:0] MAXC = {1'b0, {CNT_W{1'b1}}};

  typedef enum logic [1:0] {IDLE, LOOKUP, RESP} state_t;

  state_t              state, state_nxt;
  logic [CODE_W-1:0]   code_q;
  logic [CNT_W-1:0]    cnt     [NUM_ITEMS];
  logic [CNT_W-1:0]    cnt_nxt [NUM_ITEMS];
  logic [CNT_W:0]      sum     [NUM_ITEMS];

  logic                found;
  logic [SLOT_W-1:0]   hit_idx;
  logic [CNT_W-1:0]    hit_cnt;
  logic                latch_code;
  logic                dec_en;
  logic                ack_nxt, ok_nxt;
  logic [1:0]          err_nxt;
  logic [SLOT_W-1:0]   slot_nxt;

  // Descending scan so the lowest matching slot is the last assignment and wins.
  always_comb begin
    found   = 1'b0;
    hit_idx = '0;
    hit_cnt = '0;
    for (int i = NUM_ITEMS - 1; i >= 0; i--) begin
      if (code_q == ITEM_CODES[i*CODE_W +: CODE_W]) begin
        found   = 1'b1;
        hit_idx = SLOT_W'(i);
        hit_cnt = cnt[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    latch_code = 1'b0;
    dec_en     = 1'b0;
    ack_nxt    = 1'b0;
    ok_nxt     = 1'b0;
    err_nxt    = 2'd0;
    slot_nxt   = vend_slot;
    unique case (state)
      IDLE: begin
        if (vend_req) begin
          latch_code = 1'b1;
          state_nxt  = LOOKUP;
        end
      end
      LOOKUP: begin
        ack_nxt   = 1'b1;
        slot_nxt  = found ? hit_idx : '0;
        state_nxt = RESP;
        if (!found)              err_nxt = 2'd1;
        else if (hit_cnt == '0)  err_nxt = 2'd2;
        else begin
          ok_nxt = 1'b1;
          dec_en = 1'b1;
        end
      end
      RESP: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      code_q    <= '0;
      vend_ack  <= 1'b0;
      vend_ok   <= 1'b0;
      vend_err  <= 2'd0;
      vend_slot <= '0;
    end else begin
      if (latch_code) code_q <= item_code;
      vend_ack  <= ack_nxt;
      vend_ok   <= ok_nxt;
      vend_err  <= err_nxt;
      vend_slot <= slot_nxt;
    end
  end

  // A committed decrement implies count >= 1, so count + qty - 1 cannot underflow.
  always_comb begin
    for (int i = 0; i < NUM_ITEMS; i++) begin
      sum[i] = {1'b0, cnt[i]};
      if (restock_en && restock_slot == SLOT_W'(i))
        sum[i] = sum[i] + {1'b0, restock_qty};
      if (dec_en && hit_idx == SLOT_W'(i))
        sum[i] = sum[i] - (CNT_W+1)'(1);
      cnt_nxt[i] = (sum[i] > MAXC) ? MAXC[CNT_W-1:0] : sum[i][CNT_W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_ITEMS; i++) begin
      if (reset) cnt[i] <= INIT_COUNTS[i*CNT_W +: CNT_W];
      else       cnt[i] <= cnt_nxt[i];
    end
  end

  always_comb begin
    counts   = '0;
    sold_out = '0;
    for (int i = 0; i < NUM_ITEMS; i++) begin
      counts[i*CNT_W +: CNT_W] = cnt[i];
      sold_out[i]              = (cnt[i] == '0);
    end
  end

`ifdef LOW_STOCK_ALERT_EN
  localparam logic [CNT_W:0] LOW_T = (CNT_W+1)'(LOW_THRESH);

  function automatic logic [NUM_ITEMS-1:0] low_of(input logic [NUM_ITEMS*CNT_W-1:0] c);
    logic [NUM_ITEMS-1:0] r;
    r = '0;
    for (int i = 0; i < NUM_ITEMS; i++)
      r[i] = (c[i*CNT_W +: CNT_W] != '0) && ({1'b0, c[i*CNT_W +: CNT_W]} <= LOW_T);
    return r;
  endfunction

  always_ff @(posedge clk) begin
    if (reset) low_stock <= low_of(INIT_COUNTS);
    else       low_stock <= low_of(counts);
  end
`endif

endmodule
